// File: rtl/sprite_pkg.sv
// Shared constants and types for the sprite line scheduler.
// Palette codes, FSM states and the line-buffer word layout.
package sprite_pkg;

    localparam int SPR_SIZE = 16;
    localparam int LINE_W   = 640;

    localparam logic [1:0] PAL_ALPHA  = 2'b00;
    localparam logic [1:0] PAL_RED    = 2'b01;
    localparam logic [1:0] PAL_DBROWN = 2'b10;
    localparam logic [1:0] PAL_LBROWN = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        FETCH,
        DRAIN
    } state_t;

    typedef struct packed {
        logic [1:0] slot;
        logic [1:0] pal;
    } lb_data_t;

endpackage

// File: rtl/sprite_row_hit.sv
// Vertical range check of one sprite against the scanline being built.
// Done in 11 bits so a sprite near the bottom never wraps to the top.
module sprite_row_hit (
    input  logic [9:0] y,
    input  logic [9:0] top,
    output logic       hit,
    output logic [3:0] row
);
    import sprite_pkg::*;

    logic [10:0] diff;

    assign diff = {1'b0, y} - {1'b0, top};
    assign hit  = (y >= top) && (diff < 11'(SPR_SIZE));
    assign row  = diff[3:0];

endmodule

// File: rtl/sprite_line_scheduler.sv
// Fills the next scanline buffer from the shared sprite ROM in hblank.
// Define SPRITE_HFLIP_EN to add the per-slot horizontal flip input.
module sprite_line_scheduler #(
    parameter int NUM_SPR = 4,
    parameter int LINE_W  = 640
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  line_start,
    input  logic [9:0]            next_y,
    input  logic [NUM_SPR-1:0]    spr_en,
    input  logic [NUM_SPR*10-1:0] spr_x,
    input  logic [NUM_SPR*10-1:0] spr_y,
    input  logic [NUM_SPR*2-1:0]  spr_img,
`ifdef SPRITE_HFLIP_EN
    input  logic [NUM_SPR-1:0]    spr_flip,
`endif
    output logic [3:0]            rom_x,
    output logic [3:0]            rom_y,
    output logic [1:0]            rom_sel,
    input  logic [1:0]            rom_pal,
    output logic                  lb_we,
    output logic [9:0]            lb_addr,
    output logic [3:0]            lb_data,
    output logic                  busy,
    output logic                  done,
    output logic                  overrun
);
    import sprite_pkg::*;

    localparam int SW = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1;

    state_t        state;
    logic [SW-1:0] slot;
    logic [3:0]    col;
    logic [9:0]    ny;
    logic [9:0]    cur_x;
    logic [9:0]    cur_y;
    logic [1:0]    cur_img;
    logic          in_range;
    logic          hit;
    logic [3:0]    row;
    logic [10:0]   sum;
    lb_data_t      wd;

    assign cur_x   = spr_x[int'(slot)*10 +: 10];
    assign cur_y   = spr_y[int'(slot)*10 +: 10];
    assign cur_img = spr_img[int'(slot)*2 +: 2];
    assign hit     = spr_en[slot] & in_range;
    assign sum     = {1'b0, cur_x} + {7'b0, col};
    assign wd      = '{slot: 2'(slot), pal: rom_pal};

    sprite_row_hit u_hit (
        .y   (ny),
        .top (cur_y),
        .hit (in_range),
        .row (row)
    );

`ifdef SPRITE_HFLIP_EN
    logic flip_q;

    // 15 - col on a 4-bit counter is its bitwise inverse
    assign rom_x = col ^ {4{flip_q}};

    always_ff @(posedge Clk) begin
        if (Reset)
            flip_q <= 1'b0;
        else if (state == SCAN && hit)
            flip_q <= spr_flip[slot];
    end
`else
    assign rom_x = col;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= IDLE;
            slot    <= '0;
            col     <= '0;
            ny      <= '0;
            rom_y   <= '0;
            rom_sel <= '0;
            lb_we   <= 1'b0;
            lb_addr <= '0;
            lb_data <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            done    <= 1'b0;
            overrun <= 1'b0;
            lb_we   <= 1'b0;
            if (line_start) begin
                // a restart squashes the in-flight write via the lb_we default
                overrun <= busy;
                ny      <= next_y;
                slot    <= SW'(NUM_SPR - 1);
                col     <= '0;
                state   <= SCAN;
                busy    <= 1'b1;
            end else begin
                unique case (state)
                    IDLE: ;
                    SCAN: begin
                        if (hit) begin
                            rom_y   <= row;
                            rom_sel <= cur_img;
                            col     <= '0;
                            state   <= FETCH;
                        end else if (slot == '0) begin
                            state <= DRAIN;
                        end else begin
                            slot <= slot - SW'(1);
                        end
                    end
                    FETCH: begin
                        lb_we   <= (rom_pal != PAL_ALPHA)
                                && (sum < 11'(LINE_W));
                        lb_addr <= sum[9:0];
                        lb_data <= wd;
                        col     <= col + 4'd1;
                        if (col == 4'd15) begin
                            if (slot == '0) begin
                                state <= DRAIN;
                            end else begin
                                slot  <= slot - SW'(1);
                                state <= SCAN;
                            end
                        end
                    end
                    DRAIN: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Bench for sprite_line_scheduler: vector table plus write scoreboard.
// Also covers reset mid-fetch and line_start overrun.
module tb_sprite_line_scheduler;

    localparam int NS = 4;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          line_start = 1'b0;
    logic [9:0]    next_y = '0;
    logic [NS-1:0] spr_en = '0;
    logic [39:0]   spr_x = '0;
    logic [39:0]   spr_y = '0;
    logic [7:0]    spr_img = '0;
`ifdef SPRITE_HFLIP_EN
    logic [NS-1:0] spr_flip = '0;
`endif
    logic [3:0]    rom_x;
    logic [3:0]    rom_y;
    logic [1:0]    rom_sel;
    logic [1:0]    rom_pal;
    logic          lb_we;
    logic [9:0]    lb_addr;
    logic [3:0]    lb_data;
    logic          busy;
    logic          done;
    logic          overrun;

    typedef struct {
        logic [9:0] addr;
        logic [3:0] data;
    } wr_t;

    typedef struct {
        logic [3:0]  en;
        logic [39:0] xs;
        logic [39:0] ys;
        logic [7:0]  img;
        logic [9:0]  ny;
        int          lat;
    } vec_t;

    wr_t  exp_q[$];
    vec_t vecs[10];
    logic [3:0] lbmem[1024];
    int errors = 0;
    int checks = 0;
    int done_cnt = 0;

    sprite_line_scheduler #(.NUM_SPR(NS), .LINE_W(640)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .line_start (line_start),
        .next_y     (next_y),
        .spr_en     (spr_en),
        .spr_x      (spr_x),
        .spr_y      (spr_y),
        .spr_img    (spr_img),
`ifdef SPRITE_HFLIP_EN
        .spr_flip   (spr_flip),
`endif
        .rom_x      (rom_x),
        .rom_y      (rom_y),
        .rom_sel    (rom_sel),
        .rom_pal    (rom_pal),
        .lb_we      (lb_we),
        .lb_addr    (lb_addr),
        .lb_data    (lb_data),
        .busy       (busy),
        .done       (done),
        .overrun    (overrun)
    );

    always #5 Clk = ~Clk;

    // Row 0 is red over columns 7..13; other rows a mixed pattern.
    function automatic logic [1:0] rom_f(input logic [1:0] s,
                                         input logic [3:0] r,
                                         input logic [3:0] c);
        int v;
        if (r == 4'd0)
            return (c >= 4'd7 && c <= 4'd13) ? 2'b01 : 2'b00;
        v = int'(c) + int'(r) + int'(s);
        return 2'(v);
    endfunction

    assign rom_pal = rom_f(rom_sel, rom_y, rom_x);

    function automatic logic [39:0] pack4(input int a3, input int a2,
                                          input int a1, input int a0);
        return {10'(a3), 10'(a2), 10'(a1), 10'(a0)};
    endfunction

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    // Expected writes for one fill, truncated after `limit` fetch cycles.
    task automatic model_fill(input logic [9:0] ny, input int limit);
        int f;
        int yv;
        int d;
        int a;
        logic [1:0] pal;
        wr_t w;
        f = 0;
        for (int s = NS - 1; s >= 0; s--) begin
            yv = int'(spr_y[s*10 +: 10]);
            d  = int'(ny) - yv;
            if (spr_en[s] && d >= 0 && d < 16) begin
                for (int c = 0; c < 16; c++) begin
                    if (f < limit) begin
                        pal = rom_f(spr_img[s*2 +: 2], 4'(d), 4'(c));
                        a = int'(spr_x[s*10 +: 10]) + c;
                        if (pal != 2'b00 && a < 640) begin
                            w.addr = 10'(a);
                            w.data = {2'(s), pal};
                            exp_q.push_back(w);
                        end
                    end
                    f++;
                end
            end
        end
    endtask

    always @(negedge Clk) begin
        wr_t w;
        if (done) done_cnt++;
        if (lb_we) begin
            checks++;
            if (lb_addr >= 10'd640) begin
                errors++;
                $display("FAIL wr_range: addr %0d >= 640", lb_addr);
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wr_unexpected: addr %0d data %h",
                         lb_addr, lb_data);
            end else begin
                w = exp_q.pop_front();
                if (w.addr != lb_addr || w.data != lb_data) begin
                    errors++;
                    $display("FAIL wr_match: got %0d/%h expected %0d/%h",
                             lb_addr, lb_data, w.addr, w.data);
                end
            end
            lbmem[lb_addr] = lb_data;
        end
    end

    // Pulse line_start; returns one cycle after the sampling edge.
    task automatic start(input logic [9:0] y);
        @(posedge Clk); #1;
        next_y = y;
        line_start = 1'b1;
        @(posedge Clk); #1;
        line_start = 1'b0;
    endtask

    // Counts cycles (line_start cycle = 0) until done is seen.
    task automatic wait_done(output int n);
        n = 1;
        while (!done && n < 200) begin
            @(posedge Clk); #1;
            n++;
        end
        if (!done) begin
            errors++;
            $display("FAIL done_timeout: no done after %0d cycles", n);
        end
    endtask

    task automatic cfg(input vec_t v);
        spr_en  = v.en;
        spr_x   = v.xs;
        spr_y   = v.ys;
        spr_img = v.img;
    endtask

    initial begin
        int n;
        int d0;
        vec_t h;

        vecs[0] = '{4'b0001, pack4(0, 0, 0, 100), pack4(0, 0, 0, 50),
                    8'h00, 10'd50, 22};
        vecs[1] = '{4'b0011, pack4(0, 0, 100, 100), pack4(0, 0, 50, 50),
                    8'h04, 10'd50, 38};
        vecs[2] = '{4'b0001, pack4(0, 0, 0, 630), pack4(0, 0, 0, 50),
                    8'h00, 10'd55, 22};
        vecs[3] = '{4'b0001, pack4(0, 0, 0, 100), pack4(0, 0, 0, 50),
                    8'h00, 10'd49, 6};
        vecs[4] = '{4'b0001, pack4(0, 0, 0, 100), pack4(0, 0, 0, 50),
                    8'h00, 10'd66, 6};
        vecs[5] = '{4'b0001, pack4(0, 0, 0, 100), pack4(0, 0, 0, 50),
                    8'h02, 10'd65, 22};
        vecs[6] = '{4'b0001, pack4(0, 0, 0, 100), pack4(0, 0, 0, 1015),
                    8'h00, 10'd5, 6};
        vecs[7] = '{4'b1111, pack4(0, 200, 400, 620), pack4(40, 45, 50, 55),
                    8'b11100100, 10'd55, 70};
        vecs[8] = '{4'b0000, pack4(0, 0, 0, 100), pack4(0, 0, 0, 50),
                    8'h00, 10'd50, 6};
        vecs[9] = '{4'b1000, pack4(300, 0, 0, 0), pack4(100, 0, 0, 0),
                    8'h80, 10'd100, 22};

        repeat (3) @(posedge Clk);
        #1 Reset = 1'b0;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_we", int'(lb_we), 0);
        chk("rst_ovr", int'(overrun), 0);
        chk("rst_romx", int'(rom_x), 0);

        for (int i = 0; i < 10; i++) begin
            cfg(vecs[i]);
            model_fill(vecs[i].ny, 1000);
            start(vecs[i].ny);
            chk("busy_on", int'(busy), 1);
            wait_done(n);
            chk($sformatf("lat_v%0d", i), n, vecs[i].lat);
            chk("busy_off", int'(busy), 0);
            @(posedge Clk); #1;
            chk("done_pulse", int'(done), 0);
            chk($sformatf("drained_v%0d", i), exp_q.size(), 0);
            exp_q.delete();
            if (i == 1)
                chk("top_slot107", int'(lbmem[107][3:2]), 0);
        end

        // Reset while fetching column 7 of slot 0.
        h = vecs[0];
        cfg(h);
        d0 = done_cnt;
        start(10'd50);
        repeat (11) @(posedge Clk);
        #1;
        chk("mid_romx", int'(rom_x), 7);
        chk("mid_busy", int'(busy), 1);
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_we", int'(lb_we), 0);
        chk("rst_mid_done", int'(done), 0);
        repeat (30) @(posedge Clk);
        #1;
        chk("rst_mid_nodone", done_cnt - d0, 0);
        model_fill(10'd50, 1000);
        start(10'd50);
        wait_done(n);
        chk("post_rst_lat", n, 22);
        @(posedge Clk); #1;
        chk("post_rst_drain", exp_q.size(), 0);
        exp_q.delete();

        // Overrun 10 cycles into a fill; only 5 fetches precede the abort.
        d0 = done_cnt;
        model_fill(10'd51, 5);
        start(10'd51);
        repeat (9) @(posedge Clk);
        #1;
        model_fill(10'd50, 1000);
        next_y = 10'd50;
        line_start = 1'b1;
        @(posedge Clk); #1;
        line_start = 1'b0;
        chk("ovr_pulse", int'(overrun), 1);
        chk("ovr_busy", int'(busy), 1);
        @(posedge Clk); #1;
        chk("ovr_once", int'(overrun), 0);
        wait_done(n);
        chk("ovr_lat", n, 21);
        repeat (5) @(posedge Clk);
        #1;
        chk("ovr_one_done", done_cnt - d0, 1);
        chk("ovr_drain", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sprite_line_scheduler.md
Name: sprite_line_scheduler

Overview:
- Shares the single 16x16, 2-bit-palette sprite ROM among NUM_SPR on-screen objects (Mario, enemies).
- Fills the line buffer for the next scanline during horizontal blanking, ahead of the VGA colour mapper.
- For each object: checks vertical hit, sweeps 16 ROM columns (one per clock), and writes opaque pixels into the line buffer.

Parameters:
- NUM_SPR, 4, number of sprite slots; slot 0 has highest priority.
- LINE_W, 640, visible pixels per line; writes at x >= LINE_W are dropped.
- SPR_SIZE, 16, sprite edge in pixels (fixed at 16 by ROM addressing).

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- line_start  in  1  one-cycle pulse requesting a fill for line next_y.
- next_y  in  10  scanline to build; sampled on line_start.
- spr_en  in  NUM_SPR  per-slot enable.
- spr_x  in  NUM_SPR*10  slot left edge, slot i at [10i+9:10i].
- spr_y  in  NUM_SPR*10  slot top edge, same packing.
- spr_img  in  NUM_SPR*2  ROM image select per slot.
- rom_x  out  4  ROM column.
- rom_y  out  4  ROM row.
- rom_sel  out  2  ROM image select.
- rom_pal  in  2  combinational ROM data for the current rom_x/rom_y/rom_sel; 00 = transparent.
- lb_we  out  1  line buffer write enable.
- lb_addr  out  10  line buffer pixel address.
- lb_data  out  4  {slot index[1:0], pal[1:0]}.
- busy  out  1  fill in progress.
- done  out  1  one-cycle pulse when the fill completes.
- overrun  out  1  one-cycle pulse when line_start arrives while busy.

Behaviour:
- Reset: state=IDLE; all outputs 0; slot counter and column counter 0.
- Slot processing order is NUM_SPR-1 down to 0, so lower slots overwrite higher ones (slot 0 on top).
- IDLE: on line_start, latch next_y, set slot=NUM_SPR-1, go to SCAN; busy=1 from the next cycle.
- SCAN (1 cycle per slot):
  - hit = spr_en[slot] && next_y >= spr_y && (next_y - spr_y) < 16, compared in 11 bits (no wrap).
  - Hit: rom_y = (next_y - spr_y)[3:0], rom_sel = spr_img[slot], col=0, go to FETCH.
  - Miss: if slot==0 go to DRAIN, else slot-1 and stay in SCAN.
- FETCH (16 cycles): rom_x = col each cycle; col increments.
  - After col==15: if slot==0 go to DRAIN, else slot-1 and go to SCAN.
- Write stage (1-cycle pipeline):
  - The cycle after each FETCH cycle registers lb_addr = spr_x + col (11-bit sum), lb_data = {slot, rom_pal}.
  - lb_we=1 only if rom_pal != 00 and the sum < LINE_W.
- DRAIN: 1 cycle, lets the last write retire; then done=1 for one cycle, busy=0, go to IDLE.
- Latency: line_start to done = 1 + NUM_SPR + 16*hits + 1 cycles (4 slots, no hits: 6; all hit: 70).
- line_start while busy: overrun pulses; the current fill aborts with no further writes (a pending pipelined write is squashed); restart at SCAN with the new next_y; no done for the aborted line.
- line_start and Reset in the same cycle: Reset wins.
- The line buffer is read-and-clear by the consumer; this block never clears it.
- spr_* inputs must be stable while busy; the block re-reads them per slot and does not latch them.

Optional Feature:
- SPRITE_HFLIP_EN defined: adds input spr_flip (NUM_SPR bits); a flipped slot drives rom_x = 15 - col while lb_addr still uses spr_x + col.
- Undefined: no spr_flip port; rom_x = col always.

Decomposition:
- Package sprite_pkg: SPR_SIZE, LINE_W, palette codes (PAL_ALPHA=2'b00, PAL_RED, PAL_DBROWN, PAL_LBROWN), the state enum (IDLE, SCAN, FETCH, DRAIN), and the lb_data struct {slot, pal}.
- One sub-module: sprite_row_hit (combinational 11-bit vertical range check, returns hit and row); it is instantiated once and muxed by slot.

Test Plan:
- Reset mid-FETCH (col=7): next cycle busy=0, lb_we=0, state IDLE; no done.
- Slot0 en, x=100, y=50, img0; line_start, next_y=50 → writes only to addresses where row 0 is opaque (e.g. 107..113 for red row 0); done at cycle 22.
- Slots 0 and 1 both at x=100, y=50 → slot1 writes precede slot0 writes to the same addresses; final lb_data slot field = 0.
- Slot0 at x=630 → no lb_we for addresses >= 640.
- next_y=49 and next_y=66 with spr_y=50 → no writes, done at cycle 6; spr_y=1015, next_y=5 → no hit (no wrap).
- line_start again 10 cycles into a fill → overrun pulse, first fill aborts with no writes after the abort, second fill completes with a single done.
